// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multicycle sequencer for the 64-bit load/store/ALU datapath. It captures the
// fetched instruction into an internal IR, decodes it into an instruction class
// and walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB), driving the datapath
// strobes as Moore outputs of the current state and the IR class.
//
// Supported classes: LD, SD, ADD, SUB, ADDI, BEQ and HALT. Anything else traps.
// HALT and TRAP are sticky until reset. With step_mode=1 the unit goes back to
// IDLE after every retired instruction and waits for the next start.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        leave IDLE and begin fetching (sampled in IDLE only)
//   step_mode    1 = return to IDLE after each retired instruction
//   instruction  instruction memory output, captured in FETCH
//   zero         ALU zero flag, used in BEQ EXEC only
//   IR_load      datapath IR load strobe (FETCH)
//   WE_reg       register-file write enable
//   WE_mem       data-memory write enable
//   OP_MEM_I     ALU B-source: 0 reg B, 1 load/store offset, 2 I-type immediate
//   ADD_SUB      0 add, 1 subtract
//   PC_load      load PC (exactly once per retired instruction)
//   PC_src       0 = PC+4, 1 = PC+branch offset
//   busy         not in IDLE, HALT or TRAP
//   halted       in HALT
//   illegal      in TRAP
//   retired      retired-instruction count, wraps
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int ILEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic [ILEN-1:0]  instruction,
    input  logic             zero,
    output logic             IR_load,
    output logic             WE_reg,
    output logic             WE_mem,
    output logic [1:0]       OP_MEM_I,
    output logic             ADD_SUB,
    output logic             PC_load,
    output logic             PC_src,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_LD      = 3'd0,
        CLS_SD      = 3'd1,
        CLS_ADD     = 3'd2,
        CLS_SUB     = 3'd3,
        CLS_ADDI    = 3'd4,
        CLS_BEQ     = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } iclass_t;

    // Classify an instruction word. HALT is an exact full-word match, so it is
    // tested before the opcode table.
    function automatic iclass_t decode_class(input logic [ILEN-1:0] ir);
        iclass_t    cls;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        opcode = ir[6:0];
        funct3 = ir[14:12];
        funct7 = ir[31:25];
        cls    = CLS_ILLEGAL;
        if (ir == ILEN'(32'h0000_0073)) begin
            cls = CLS_HALT;
        end else begin
            case (opcode)
                7'b0000011: cls = (funct3 == 3'b011) ? CLS_LD : CLS_ILLEGAL;
                7'b0100011: cls = (funct3 == 3'b011) ? CLS_SD : CLS_ILLEGAL;
                7'b0010011: cls = (funct3 == 3'b000) ? CLS_ADDI : CLS_ILLEGAL;
                7'b1100011: cls = (funct3 == 3'b000) ? CLS_BEQ : CLS_ILLEGAL;
                7'b0110011: begin
                    if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                        cls = CLS_ADD;
                    end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                        cls = CLS_SUB;
                    end else begin
                        cls = CLS_ILLEGAL;
                    end
                end
                default:    cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    state_t           retire_next_s;
    logic [ILEN-1:0]  ir_r;
    logic [CNT_W-1:0] retired_r;
    iclass_t          cls_s;
    logic             retire_s;
    logic [1:0]       exec_op_s;
    logic             exec_as_s;
    logic             ir_load_s;
    logic             we_reg_s;
    logic             we_mem_s;
    logic [1:0]       op_mem_i_s;
    logic             add_sub_s;
    logic             pc_load_s;
    logic             pc_src_s;

    // Decode always works from the captured IR, never the live port.
    assign cls_s = decode_class(ir_r);

    // Where a retiring instruction goes next; step_mode is sampled in the retire cycle.
    assign retire_next_s = step_mode ? S_IDLE : S_FETCH;

    // State, instruction register and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            ir_r      <= {ILEN{1'b0}};
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == S_FETCH) begin
                ir_r <= instruction;
            end else begin
                ir_r <= ir_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // ALU controls chosen in EXEC; WB repeats them so the datapath result stays stable.
    always_comb begin
        exec_op_s = 2'd0;
        exec_as_s = 1'b0;
        case (cls_s)
            CLS_LD, CLS_SD: exec_op_s = 2'd1;
            CLS_ADDI:       exec_op_s = 2'd2;
            CLS_SUB:        exec_as_s = 1'b1;
            CLS_BEQ:        exec_as_s = 1'b1;
            default: begin
                exec_op_s = 2'd0;
                exec_as_s = 1'b0;
            end
        endcase
    end

    // Next-state logic and Moore strobes.
    always_comb begin
        state_next_s = state_r;
        retire_s     = 1'b0;
        ir_load_s    = 1'b0;
        we_reg_s     = 1'b0;
        we_mem_s     = 1'b0;
        op_mem_i_s   = 2'd0;
        add_sub_s    = 1'b0;
        pc_load_s    = 1'b0;
        pc_src_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                ir_load_s    = 1'b1;
                state_next_s = S_DECODE;
            end
            S_DECODE: begin
                case (cls_s)
                    CLS_HALT:    state_next_s = S_HALT;
                    CLS_ILLEGAL: state_next_s = S_TRAP;
                    default:     state_next_s = S_EXEC;
                endcase
            end
            S_EXEC: begin
                op_mem_i_s = exec_op_s;
                add_sub_s  = exec_as_s;
                case (cls_s)
                    CLS_LD, CLS_SD:             state_next_s = S_MEM;
                    CLS_ADD, CLS_SUB, CLS_ADDI: state_next_s = S_WB;
                    CLS_BEQ: begin
                        pc_load_s    = 1'b1;
                        pc_src_s     = zero;
                        retire_s     = 1'b1;
                        state_next_s = retire_next_s;
                    end
                    // HALT/ILLEGAL never reach EXEC; trap if the IR is ever inconsistent.
                    default:                    state_next_s = S_TRAP;
                endcase
            end
            S_MEM: begin
                op_mem_i_s = 2'd1;
                case (cls_s)
                    CLS_LD: state_next_s = S_WB;
                    CLS_SD: begin
                        we_mem_s     = 1'b1;
                        pc_load_s    = 1'b1;
                        retire_s     = 1'b1;
                        state_next_s = retire_next_s;
                    end
                    default: state_next_s = S_TRAP;
                endcase
            end
            S_WB: begin
                we_reg_s     = 1'b1;
                op_mem_i_s   = exec_op_s;
                add_sub_s    = exec_as_s;
                pc_load_s    = 1'b1;
                retire_s     = 1'b1;
                state_next_s = retire_next_s;
            end
            S_HALT:  state_next_s = S_HALT;
            S_TRAP:  state_next_s = S_TRAP;
            default: state_next_s = S_IDLE;
        endcase
    end

    assign IR_load  = ir_load_s;
    assign WE_reg   = we_reg_s;
    assign WE_mem   = we_mem_s;
    assign OP_MEM_I = op_mem_i_s;
    assign ADD_SUB  = add_sub_s;
    assign PC_load  = pc_load_s;
    assign PC_src   = pc_src_s;
    assign busy     = (state_r != S_IDLE) && (state_r != S_HALT) && (state_r != S_TRAP);
    assign halted   = (state_r == S_HALT);
    assign illegal  = (state_r == S_TRAP);
    assign retired  = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Scoreboard bench. Every issued instruction pushes an expected record built
// from the instruction-class rules (latency, write strobes, ALU controls,
// branch select, retire count). A negedge monitor gathers what the DUT did
// between IR_load and the retire/halt/trap event and compares. A second
// instance with CNT_W=4 runs in lockstep to exercise counter wrap.
// ----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        zero = 1'b0;
    logic        IR_load, WE_reg, WE_mem, ADD_SUB, PC_load, PC_src, busy, halted, illegal;
    logic [1:0]  OP_MEM_I;
    logic [31:0] retired;
    logic        d4_ir_load, d4_we_reg, d4_we_mem, d4_add_sub, d4_pc_load, d4_pc_src;
    logic        d4_busy, d4_halted, d4_illegal;
    logic [1:0]  d4_op;
    logic [3:0]  d4_retired;
    logic [10:0] outs_vec, d4_vec;

    multicycle_control_unit #(.ILEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
        .instruction(instruction), .zero(zero),
        .IR_load(IR_load), .WE_reg(WE_reg), .WE_mem(WE_mem), .OP_MEM_I(OP_MEM_I),
        .ADD_SUB(ADD_SUB), .PC_load(PC_load), .PC_src(PC_src), .busy(busy),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    multicycle_control_unit #(.ILEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
        .instruction(instruction), .zero(zero),
        .IR_load(d4_ir_load), .WE_reg(d4_we_reg), .WE_mem(d4_we_mem), .OP_MEM_I(d4_op),
        .ADD_SUB(d4_add_sub), .PC_load(d4_pc_load), .PC_src(d4_pc_src), .busy(d4_busy),
        .halted(d4_halted), .illegal(d4_illegal), .retired(d4_retired)
    );

    assign outs_vec = {IR_load, WE_reg, WE_mem, OP_MEM_I, ADD_SUB, PC_load, PC_src, busy, halted, illegal};
    assign d4_vec   = {d4_ir_load, d4_we_reg, d4_we_mem, d4_op, d4_add_sub, d4_pc_load, d4_pc_src,
                       d4_busy, d4_halted, d4_illegal};

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // kind: 0 retires, 1 halts, 2 traps
    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  lat;
        logic [1:0]  n_wr;
        logic [1:0]  n_wm;
        logic [1:0]  op_ex;
        logic        as_ex;
        logic [1:0]  op_ret;
        logic        as_ret;
        logic        pc_src;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    int          we_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_retired = 32'd0;
    bit          mon_en = 1'b0;
    int          start_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    // Reference: what each instruction should do, from the class table.
    function automatic exp_t model(input logic [31:0] i, input logic z);
        exp_t e;
        e = '0;
        if (i == 32'h0000_0073) begin
            e.kind = 2'd1; e.lat = 4'd3;
        end else if ((i & 32'h0000_707F) == 32'h0000_3003) begin
            e.lat = 4'd5; e.n_wr = 2'd1; e.op_ex = 2'd1; e.op_ret = 2'd1;
        end else if ((i & 32'h0000_707F) == 32'h0000_3023) begin
            e.lat = 4'd4; e.n_wm = 2'd1; e.op_ex = 2'd1; e.op_ret = 2'd1;
        end else if ((i & 32'hFE00_707F) == 32'h0000_0033) begin
            e.lat = 4'd4; e.n_wr = 2'd1;
        end else if ((i & 32'hFE00_707F) == 32'h4000_0033) begin
            e.lat = 4'd4; e.n_wr = 2'd1; e.as_ex = 1'b1; e.as_ret = 1'b1;
        end else if ((i & 32'h0000_707F) == 32'h0000_0013) begin
            e.lat = 4'd4; e.n_wr = 2'd1; e.op_ex = 2'd2; e.op_ret = 2'd2;
        end else if ((i & 32'h0000_707F) == 32'h0000_0063) begin
            e.lat = 4'd3; e.as_ex = 1'b1; e.as_ret = 1'b1; e.pc_src = z;
        end else begin
            e.kind = 2'd2; e.lat = 4'd3;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr(input int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            0:       return {r[31:15], 3'b011, r[11:7], 7'b0000011};
            1:       return {r[31:15], 3'b011, r[11:7], 7'b0100011};
            2:       return {7'b0000000, r[24:15], 3'b000, r[11:7], 7'b0110011};
            3:       return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
            4:       return {r[31:15], 3'b000, r[11:7], 7'b0010011};
            default: return {r[31:15], 3'b000, r[11:7], 7'b1100011};
        endcase
    endfunction

    task automatic push_expect(input logic [31:0] instr, input logic z);
        exp_t e;
        e = model(instr, z);
        if (e.kind == 2'd0) begin
            exp_retired = exp_retired + 32'd1;
            e.ret = exp_retired;
        end
        exp_q.push_back(e);
    endtask

    // Present instr until it is fetched, then put junk on the port during DECODE.
    task automatic issue(input logic [31:0] instr, input logic z);
        bit seen;
        push_expect(instr, z);
        instruction = instr;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (IR_load) seen = 1'b1;
        end
        if (!seen) begin
            fail_now("fetch_timeout");
        end else begin
            @(posedge clk); #1;
            zero = z;
            instruction = $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cycle_cnt;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_retired = 32'd0;
        check("reset_outs", outs_vec, 11'd0);
        check("reset_retired", retired, 32'd0);
        check("reset_outs_w4", {d4_vec, d4_retired}, 15'd0);
    endtask

    // Wait for PC_load at a negedge, bounded.
    task automatic wait_pc_load(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (PC_load) seen = 1'b1;
        end
        if (!seen) fail_now(name);
    endtask

    // Monitor state
    bit         in_flight = 1'b0;
    int         cyc, nwr, nwm, ncoin;
    logic [1:0] op_ex_o, op_wm_o;
    logic       as_ex_o;
    bit         ret_pend = 1'b0;
    logic [31:0] ret_exp;

    // Scoreboard monitor: collects each instruction's behaviour and compares on retire/halt/trap.
    always @(negedge clk) begin
        exp_t e;
        int   obs;
        if (!mon_en) begin
            in_flight = 1'b0;
            ret_pend  = 1'b0;
        end else begin
            if (ret_pend) begin
                check("retired", retired, ret_exp);
                check("retired_w4", d4_retired, ret_exp[3:0]);
                ret_pend = 1'b0;
            end
            if (WE_reg) we_q.push_back(cycle_cnt);
            if (IR_load) begin
                in_flight = 1'b1; cyc = 1; nwr = 0; nwm = 0; ncoin = 0; op_wm_o = 2'd0;
            end else if (in_flight) begin
                cyc++;
            end
            if (in_flight) begin
                nwr += int'(WE_reg);
                nwm += int'(WE_mem);
                if (WE_reg && WE_mem) ncoin++;
                if (WE_mem) op_wm_o = OP_MEM_I;
                if (cyc == 3) begin
                    op_ex_o = OP_MEM_I;
                    as_ex_o = ADD_SUB;
                end
                if (PC_load || halted || illegal) begin
                    obs = PC_load ? 0 : (halted ? 1 : 2);
                    in_flight = 1'b0;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_event");
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", obs, e.kind);
                        check("latency", cyc, e.lat);
                        if (e.kind == 2'd0 && obs == 0) begin
                            check("n_we_reg", nwr, e.n_wr);
                            check("n_we_mem", nwm, e.n_wm);
                            check("we_coincident", ncoin, 0);
                            check("op_exec", op_ex_o, e.op_ex);
                            check("add_sub_exec", as_ex_o, e.as_ex);
                            check("op_retire", OP_MEM_I, e.op_ret);
                            check("add_sub_retire", ADD_SUB, e.as_ret);
                            check("pc_src", PC_src, e.pc_src);
                            if (e.n_wm != 2'd0) check("op_at_we_mem", op_wm_o, 2'd1);
                            ret_pend = 1'b1;
                            ret_exp  = e.ret;
                        end else if (obs != 0) begin
                            check("no_write_before_stop", nwr + nwm, 0);
                        end
                    end
                end else if (cyc > 12) begin
                    in_flight = 1'b0;
                    fail_now("retire_timeout");
                end
            end else if (PC_load) begin
                fail_now("stray_pc_load");
            end
        end
    end

    logic [31:0] ill_pat [7];
    int          bad;

    initial begin
        ill_pat[0] = 32'h0000_007F;  // undefined opcode
        ill_pat[1] = 32'h0000_2003;  // load, wrong funct3
        ill_pat[2] = 32'h0200_0033;  // R-type, funct7 not add/sub
        ill_pat[3] = 32'h4000_1033;  // sub funct7, wrong funct3
        ill_pat[4] = 32'h0010_0073;  // system opcode, not the halt word
        ill_pat[5] = 32'h0000_0074;  // one off the halt word
        ill_pat[6] = 32'h0000_0073;  // halt after a fresh reset

        // Directed program: LD, LD, ADD, SUB, SD, BEQ taken, BEQ not taken.
        do_reset();
        mon_en = 1'b1;
        we_q.delete();
        start_pulse();
        issue(32'h0010_3083, 1'b0);
        issue(32'h0020_3103, 1'b0);
        issue(32'h0020_81B3, 1'b0);
        issue(32'h4011_8233, 1'b0);
        issue(32'h0030_31A3, 1'b0);
        issue(32'h0020_8063, 1'b1);
        issue(32'h0020_8063, 1'b0);
        // Random legal stream, then halt.
        for (int n = 0; n < 40; n++) begin
            issue(rand_instr(int'($urandom_range(0, 5))), 1'($urandom_range(0, 1)));
        end
        issue(32'h0000_0073, 1'b0);
        wait_drain();
        if (we_q.size() < 3) begin
            fail_now("we_reg_pulses");
        end else begin
            check("we_reg_cycle_ld1", we_q[0] - start_cyc + 1, 5);
            check("we_reg_cycle_ld2", we_q[1] - start_cyc + 1, 10);
            check("we_reg_cycle_add", we_q[2] - start_cyc + 1, 14);
        end
        check("retired_after_stream", retired, exp_retired);

        // Illegal patterns and halt, each after a fresh reset; start must stay ignored.
        for (int p = 0; p < 7; p++) begin
            exp_t e;
            do_reset();
            mon_en = 1'b1;
            e = model(ill_pat[p], 1'b0);
            start_pulse();
            issue(ill_pat[p], 1'b0);
            wait_drain();
            @(negedge clk);
            start = 1'b1;
            bad = 0;
            repeat (4) begin
                @(negedge clk);
                if ({halted, illegal, busy, IR_load, PC_load} !== {e.kind == 2'd1, e.kind == 2'd2, 3'b000})
                    bad++;
            end
            start = 1'b0;
            check($sformatf("sticky_stop_%0d", p), bad, 0);
            check($sformatf("stop_retired_%0d", p), retired, 32'd0);
        end

        // Single-step with start held high: one idle cycle, then refetch.
        do_reset();
        mon_en = 1'b1;
        step_mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        issue(32'h00A2_0493, 1'b0);
        push_expect(32'h00A2_0493, 1'b0);
        instruction = 32'h00A2_0493;
        wait_pc_load("step_retire1");
        @(negedge clk);
        check("step_idle_busy", {busy, IR_load}, 2'b00);
        @(negedge clk);
        check("step_refetch", IR_load, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
        instruction = $urandom;
        wait_pc_load("step_retire2");
        @(negedge clk);
        check("step_idle_after_wb", busy, 1'b0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || IR_load) bad++;
        end
        check("step_waits_for_start", bad, 0);
        check("retired_pre_rst", retired, exp_retired);

        // Reset during LD MEM: back to IDLE, everything zero, no write-back.
        mon_en = 1'b0;
        step_mode = 1'b0;
        instruction = 32'h0010_3083;
        start_pulse();
        bad = 1;
        for (int k = 0; k < 5 && bad != 0; k++) begin
            @(negedge clk);
            if (IR_load) bad = 0;
        end
        check("rst_test_fetch", bad, 0);
        @(posedge clk); #1;
        instruction = $urandom;
        repeat (3) @(negedge clk);
        check("ld_mem_strobes", {WE_reg, WE_mem, OP_MEM_I, PC_load}, 5'b00010);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_outs", outs_vec, 11'd0);
        check("rst_mid_retired", retired, 32'd0);
        check("rst_mid_retired_w4", d4_retired, 4'd0);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (WE_reg || WE_mem || busy) bad++;
        end
        check("rst_mid_no_write", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
